// File: rtl/pool_pkg.sv
// ---------------------------------------------------------------------------
// Module      : pool_pkg
// Description : shared types and sizing for the 2x2 pooling stage.
// Revision    : Rev 1.1
// ---------------------------------------------------------------------------
`default_nettype none

package pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_type_e;

    localparam int WID = 16;

    localparam int AW = 8;

    localparam int MAX_ROW = 256;

endpackage

`default_nettype wire

// File: rtl/pool_line_buf.sv
// ---------------------------------------------------------------------------
// pool_line_buf : half-row store of horizontal pair results.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pool_line_buf
  import pool_pkg::*;
#(
  parameter int DEPTH = MAX_ROW / 2,
  parameter int W     = WID + 1,
  parameter int ABITS = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [ABITS-1:0] raddr,
  output logic [W-1:0]     rdata
);

  // Contents are never cleared; every read slot is written one row earlier.
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/pool_2x2_stream.sv
// ---------------------------------------------------------------------------
// pool_2x2_stream : streaming 2x2 stride-2 max/average pooling.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pool_2x2_stream
  import pool_pkg::*;
#(
  parameter int WID     = pool_pkg::WID,
  parameter int MAX_ROW = pool_pkg::MAX_ROW,
  parameter int AW      = pool_pkg::AW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pool_enable,
  input  logic           pool_type,
  input  logic           line_buffer_reset,
  input  logic [AW-1:0]  row_length,
  input  logic           in_valid,
  input  logic [WID-1:0] in_data,
  output logic           out_valid,
  output logic [WID-1:0] out_data,
  output logic           out_row_end
);

  localparam int BAW = $clog2(MAX_ROW / 2);

  logic [AW-1:0]         col;
  logic [AW-1:0]         len_q;
  logic                  row_odd;
  logic signed [WID-1:0] pair;

  logic signed [WID-1:0] pix;
  logic [AW-1:0]         half_w;
  logic [AW-1:0]         even_len;
  logic                  in_window;
  logic                  last_col;
  logic                  row_end_hit;
  logic                  is_avg;
  logic                  buf_we;

  logic signed [WID:0]   h_sum, h_max, h_val, buf_rd;
  logic signed [WID+1:0] v_sum;
  logic signed [WID:0]   v_max;
  logic [WID-1:0]        result;

  assign pix         = in_data;
  assign is_avg      = (pool_type_e'(pool_type) == POOL_AVG);
  assign half_w      = len_q >> 1;
  assign even_len    = {len_q[AW-1:1], 1'b0};
  assign in_window   = (col < even_len);
  assign last_col    = (col == len_q - 1'b1);
  assign row_end_hit = ((col >> 1) == half_w - 1'b1);

  // Partial sums are carried at full precision; max operands are sign-extended
  // to the same width so one datapath serves both pooling modes.
  always_comb begin
    h_sum  = {pair[WID-1], pair} + {pix[WID-1], pix};
    h_max  = (pix > pair) ? {pix[WID-1], pix} : {pair[WID-1], pair};
    h_val  = is_avg ? h_sum : h_max;
    v_sum  = {buf_rd[WID], buf_rd} + {h_val[WID], h_val};
    v_max  = (h_val > buf_rd) ? h_val : buf_rd;
    result = is_avg ? WID'(v_sum >>> 2) : WID'(v_max);
  end

  assign buf_we = in_valid && pool_enable && in_window && col[0] && !row_odd
                  && !line_buffer_reset;

  pool_line_buf #(
    .DEPTH (MAX_ROW / 2),
    .W     (WID + 1)
  ) u_line_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (col[BAW:1]),
    .wdata (h_val),
    .raddr (col[BAW:1]),
    .rdata (buf_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col         <= '0;
      len_q       <= '0;
      row_odd     <= 1'b0;
      pair        <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_row_end <= 1'b0;
    end else if (line_buffer_reset) begin
      // out_data deliberately holds; the coincident input sample is dropped.
      col         <= '0;
      len_q       <= row_length;
      row_odd     <= 1'b0;
      pair        <= '0;
      out_valid   <= 1'b0;
      out_row_end <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      out_row_end <= 1'b0;
      if (in_valid) begin
        col <= last_col ? '0 : col + 1'b1;
        if (last_col) begin
          row_odd <= ~row_odd;
        end
        if (!pool_enable) begin
          out_valid <= 1'b1;
          out_data  <= in_data;
        end else if (in_window) begin
          if (!col[0]) begin
            pair <= pix;
          end else if (row_odd) begin
            out_valid   <= 1'b1;
            out_data    <= result;
            out_row_end <= row_end_hit;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pool_2x2_stream.sv
// ---------------------------------------------------------------------------
// tb_pool_2x2_stream : directed self-checking bench for pool_2x2_stream.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pool_2x2_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        pool_enable;
  logic        pool_type;
  logic        line_buffer_reset;
  logic [7:0]  row_length;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_row_end;

  pool_2x2_stream dut (
    .clk               (clk),
    .rst               (rst),
    .pool_enable       (pool_enable),
    .pool_type         (pool_type),
    .line_buffer_reset (line_buffer_reset),
    .row_length        (row_length),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_row_end       (out_row_end)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int qd[$];
  int qe[$];
  int qc[$];

  always @(negedge clk) begin
    if (out_valid) begin
      qd.push_back(int'($signed(out_data)));
      qe.push_back(int'(out_row_end));
      qc.push_back(cyc);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int last_cyc = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input int d);
    @(negedge clk);
    in_valid = v;
    in_data  = 16'(d);
    last_cyc = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0);
  endtask

  task automatic lbr(input int len, input bit pe, input bit pt, input bit v, input int d);
    @(negedge clk);
    line_buffer_reset = 1'b1;
    row_length        = 8'(len);
    pool_enable       = pe;
    pool_type         = pt;
    in_valid          = v;
    in_data           = 16'(d);
    @(negedge clk);
    line_buffer_reset = 1'b0;
    in_valid          = 1'b0;
  endtask

  task automatic send_row(input int px[$]);
    foreach (px[i]) drive(1'b1, px[i]);
  endtask

  // c < 0 skips the latency comparison.
  task automatic expect_out(input string tag, input int d, input int e, input int c);
    check({tag, "_present"}, int'(qd.size() > 0), 1);
    if (qd.size() > 0) begin
      check({tag, "_data"}, qd[0], d);
      check({tag, "_row_end"}, qe[0], e);
      if (c >= 0) check({tag, "_latency_cyc"}, qc[0], c);
      void'(qd.pop_front());
      void'(qe.pop_front());
      void'(qc.pop_front());
    end
  endtask

  task automatic clear_q();
    qd.delete();
    qe.delete();
    qc.delete();
  endtask

  int frame [4][8];

  task automatic run_frame(input bit pt, input bit gaps);
    int s, m, exp_d;
    lbr(8, 1'b1, pt, 1'b0, 0);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (gaps) begin
          while ($urandom_range(0, 1) == 1) drive(1'b0, 0);
        end
        drive(1'b1, frame[r][c]);
      end
    end
    idle(3);
    check(gaps ? "gap_count" : "nogap_count", qd.size(), 8);
    for (int r = 0; r < 4; r += 2) begin
      for (int c = 0; c < 8; c += 2) begin
        s = frame[r][c] + frame[r][c+1] + frame[r+1][c] + frame[r+1][c+1];
        m = frame[r][c];
        if (frame[r][c+1]   > m) m = frame[r][c+1];
        if (frame[r+1][c]   > m) m = frame[r+1][c];
        if (frame[r+1][c+1] > m) m = frame[r+1][c+1];
        exp_d = pt ? (s >>> 2) : m;
        expect_out(gaps ? "gap_px" : "nogap_px", exp_d, int'(c == 6), -1);
      end
    end
  endtask

  int c1, c3;

  initial begin
    rst = 1'b1;
    pool_enable = 1'b1;
    pool_type = 1'b0;
    line_buffer_reset = 1'b0;
    row_length = 8'd0;
    in_valid = 1'b0;
    in_data = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_row_end", int'(out_row_end), 0);
    rst = 1'b0;

    // max, len 4
    lbr(4, 1'b1, 1'b0, 1'b0, 0);
    send_row('{1, 5, -2, 3});
    drive(1'b1, 7); drive(1'b1, 0); c1 = last_cyc;
    drive(1'b1, 4); drive(1'b1, -8); c3 = last_cyc;
    idle(3);
    expect_out("max4_a", 7, 0, c1);
    expect_out("max4_b", 4, 1, c3);
    check("max4_extra", qd.size(), 0);

    // out_data holds across line_buffer_reset
    lbr(2, 1'b1, 1'b1, 1'b0, 0);
    check("lbr_hold_data", int'($signed(out_data)), 4);

    // average, len 2, floor toward -inf and full-scale
    send_row('{-1, -2}); send_row('{-3, -1});
    send_row('{32767, 32767}); send_row('{32767, 32767});
    idle(3);
    expect_out("avg_neg", -2, 1, -1);
    expect_out("avg_full", 32767, 1, -1);

    // odd length: last column ignored
    lbr(5, 1'b1, 1'b0, 1'b0, 0);
    send_row('{1, 2, 3, 4, 99}); send_row('{1, 2, 3, 4, 99});
    send_row('{5, 6, 7, 8, 50}); send_row('{1, 1, 1, 1, 1});
    idle(3);
    expect_out("odd_a", 2, 0, -1);
    expect_out("odd_b", 4, 1, -1);
    expect_out("odd_c", 6, 0, -1);
    expect_out("odd_d", 8, 1, -1);
    check("odd_extra", qd.size(), 0);

    // 8x4 frames: gapless max, gapped avg and gapped max
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        frame[r][c] = int'($urandom_range(0, 200)) - 100;
    run_frame(1'b0, 1'b0);
    run_frame(1'b1, 1'b1);
    run_frame(1'b0, 1'b1);

    // bypass
    lbr(4, 1'b0, 1'b0, 1'b0, 0);
    drive(1'b1, 10); c1 = last_cyc;
    drive(1'b1, 20);
    drive(1'b1, 30);
    idle(3);
    expect_out("byp_10", 10, 0, c1);
    expect_out("byp_20", 20, 0, -1);
    expect_out("byp_30", 30, 0, -1);

    // async reset mid-row right after an output
    lbr(4, 1'b1, 1'b0, 1'b0, 0);
    send_row('{1, 5, -2, 3});
    drive(1'b1, 7); drive(1'b1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", int'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_data", int'(out_data), 0);
    check("async_rst_row_end", int'(out_row_end), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_q();

    // length cleared by reset: nothing pools
    send_row('{9, 9, 9, 9, 9, 9});
    idle(3);
    check("len0_no_output", qd.size(), 0);

    // fresh frame; sample coincident with line_buffer_reset is dropped
    lbr(4, 1'b1, 1'b0, 1'b1, 100);
    send_row('{2, 1, 0, 0}); send_row('{0, 0, -5, 9});
    idle(3);
    expect_out("fresh_a", 2, 0, -1);
    expect_out("fresh_b", 9, 1, -1);
    check("fresh_extra", qd.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
